// File: rtl/sdram_port_client.sv
// Requesting side of the controller's toggle req/ack client port: posted write FIFO, reads ordered
// behind writes, read data captured a fixed number of clocks after the ack.
module sdram_port_client #(
  parameter int AW         = 17,
  parameter int FIFO_AW    = 2,
  parameter int DOUT_DELAY = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic          cpu_rd_i,
  input  logic          cpu_wr_i,
  input  logic [7:0]    cpu_din_i,
  output logic          cpu_busy_o,
  output logic [7:0]    cpu_dout_o,
  output logic          cpu_rvalid_o,
  output logic          mem_req_o,
  input  logic          mem_ack_i,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [7:0]    mem_din_o,
  input  logic [7:0]    mem_dout_i
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = (DOUT_DELAY > 1) ? $clog2(DOUT_DELAY) : 1;

  typedef enum logic [2:0] {S_SYNC, S_IDLE, S_WBUSY, S_RBUSY, S_RDLY} state_t;

  state_t          state_q, state_d;
  logic            mem_req_q, mem_req_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic            mem_we_q, mem_we_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic [CW-1:0]   dly_cnt_q, dly_cnt_d;
  logic [7:0]      cpu_dout_q, cpu_dout_d;
  logic            rvalid_q, rvalid_d;
  logic            read_pend_q, read_pend_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [FIFO_AW:0] wptr_q, rptr_q;
  logic [AW-1:0]   fifo_addr_q [DEPTH];
  logic [7:0]      fifo_din_q  [DEPTH];

  logic fifo_empty_s, fifo_full_s, ack_match_s, push_s, rd_acc_s, pop_s;

  assign fifo_empty_s = (wptr_q == rptr_q);
  assign fifo_full_s  = (wptr_q[FIFO_AW] != rptr_q[FIFO_AW]) &&
                        (wptr_q[FIFO_AW-1:0] == rptr_q[FIFO_AW-1:0]);
  assign ack_match_s  = (mem_ack_i == mem_req_q);
  assign cpu_busy_o   = (state_q == S_SYNC) | read_pend_q | fifo_full_s;
  assign push_s       = cpu_wr_i & ~cpu_busy_o;
  assign rd_acc_s     = cpu_rd_i & ~cpu_busy_o;

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_we_o     = mem_we_q;
  assign mem_din_o    = mem_din_q;
  assign cpu_dout_o   = cpu_dout_q;
  assign cpu_rvalid_o = rvalid_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_din_d   = mem_din_q;
    dly_cnt_d   = dly_cnt_q;
    cpu_dout_d  = cpu_dout_q;
    rvalid_d    = 1'b0;
    read_pend_d = read_pend_q;
    rd_addr_d   = rd_addr_q;
    pop_s       = 1'b0;
    if (rd_acc_s) begin
      read_pend_d = 1'b1;
      rd_addr_d   = cpu_addr_i;
    end else begin
      rd_addr_d   = rd_addr_q;
    end
    case (state_q)
      S_SYNC: begin
        if (ack_match_s) begin
          state_d    = S_IDLE;
          mem_addr_d = '0;
          mem_we_d   = 1'b0;
          mem_din_d  = 8'h00;
        end else begin
          state_d    = S_SYNC;
        end
      end
      // Writes always win over a pending read so reads observe posted data.
      S_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s      = 1'b1;
          mem_addr_d = fifo_addr_q[rptr_q[FIFO_AW-1:0]];
          mem_din_d  = fifo_din_q[rptr_q[FIFO_AW-1:0]];
          mem_we_d   = 1'b1;
          mem_req_d  = ~mem_req_q;
          state_d    = S_WBUSY;
        end else if (read_pend_q) begin
          mem_addr_d = rd_addr_q;
          mem_we_d   = 1'b0;
          mem_req_d  = ~mem_req_q;
          state_d    = S_RBUSY;
        end else begin
          state_d    = S_IDLE;
        end
      end
      S_WBUSY: begin
        if (ack_match_s) state_d = S_IDLE;
        else             state_d = S_WBUSY;
      end
      S_RBUSY: begin
        if (ack_match_s) begin
          dly_cnt_d = CW'(DOUT_DELAY - 1);
          state_d   = S_RDLY;
        end else begin
          state_d   = S_RBUSY;
        end
      end
      S_RDLY: begin
        if (dly_cnt_q == '0) begin
          cpu_dout_d  = mem_dout_i;
          rvalid_d    = 1'b1;
          read_pend_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          dly_cnt_d   = dly_cnt_q - CW'(1);
        end
      end
      default: state_d = S_SYNC;
    endcase
    // An in-flight transaction keeps its address/data until acked; SYNC clears them afterwards.
    if (reset) begin
      state_d     = S_SYNC;
      mem_req_d   = mem_req_q;
      read_pend_d = 1'b0;
      rvalid_d    = 1'b0;
      cpu_dout_d  = 8'h00;
      dly_cnt_d   = '0;
      pop_s       = 1'b0;
      if (ack_match_s) begin
        mem_addr_d = '0;
        mem_we_d   = 1'b0;
        mem_din_d  = 8'h00;
      end else begin
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        mem_din_d  = mem_din_q;
      end
    end else begin
      pop_s = pop_s;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    mem_req_q   <= mem_req_d;
    mem_addr_q  <= mem_addr_d;
    mem_we_q    <= mem_we_d;
    mem_din_q   <= mem_din_d;
    dly_cnt_q   <= dly_cnt_d;
    cpu_dout_q  <= cpu_dout_d;
    rvalid_q    <= rvalid_d;
    read_pend_q <= read_pend_d;
    rd_addr_q   <= rd_addr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_s) begin
        fifo_addr_q[wptr_q[FIFO_AW-1:0]] <= cpu_addr_i;
        fifo_din_q[wptr_q[FIFO_AW-1:0]]  <= cpu_din_i;
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop_s) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

endmodule
